// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the LCD row scheduler.
package lcd_pkg;

    // Characters in one display row, and the bit width of one row image.
    localparam int CHARS_PER_ROW = 20;
    localparam int ROW_BITS      = CHARS_PER_ROW * 8;

    // HD44780-style "set DDRAM address" opcode; the address is OR-ed into it.
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // DDRAM start address of each physical row.
    localparam logic [7:0] DDRAM_ROW0 = 8'h00;
    localparam logic [7:0] DDRAM_ROW1 = 8'h40;
    localparam logic [7:0] DDRAM_ROW2 = 8'h14;
    localparam logic [7:0] DDRAM_ROW3 = 8'h54;

    // Scheduler states, one row transfer walks PICK through ROW_END.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PICK      = 3'd1,
        ST_CMD       = 3'd2,
        ST_ROW_START = 3'd3,
        ST_ROW_DATA  = 3'd4,
        ST_ROW_END   = 3'd5
    } state_t;

    // Width of a row index; a single-row display still needs one bit.
    function automatic int row_idx_w(input int n_rows);
        return (n_rows > 1) ? $clog2(n_rows) : 1;
    endfunction

    // DDRAM base address for a row number.
    function automatic logic [7:0] ddram_base(input int row);
        case (row)
            0:       return DDRAM_ROW0;
            1:       return DDRAM_ROW1;
            2:       return DDRAM_ROW2;
            3:       return DDRAM_ROW3;
            default: return DDRAM_ROW0;
        endcase
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin finder: first set pending bit after last_row,
// wrapping modulo N_ROWS. valid is low when nothing is pending.
module lcd_rr_pick
    import lcd_pkg::*;
#(
    parameter int N_ROWS = 2,
    localparam int RW    = row_idx_w(N_ROWS)
) (
    input  logic [N_ROWS-1:0] pending,
    input  logic [RW-1:0]     last_row,
    output logic [RW-1:0]     sel,
    output logic              valid
);

    logic [RW:0]   cand;
    logic [RW-1:0] idx;

    // Walk candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        sel   = '0;
        valid = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = N_ROWS; k >= 1; k--) begin
            cand = {1'b0, last_row} + (RW+1)'(k);
            if (cand >= (RW+1)'(N_ROWS)) begin
                cand = cand - (RW+1)'(N_ROWS);
            end
            idx = cand[RW-1:0];
            if (pending[idx]) begin
                sel   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_row_scheduler.sv
// Row scheduler: queues per-row update requests, serves them round-robin,
// and for each row sends the DDRAM address command, starts the row
// serializer, counts the character acks and waits for row completion.
module lcd_row_scheduler
    import lcd_pkg::*;
#(
    parameter int N_ROWS = 2,
    parameter int CHARS  = CHARS_PER_ROW
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic [N_ROWS*ROW_BITS-1:0]   DB_All,
    input  logic [N_ROWS-1:0]            Row_Req,
    input  logic                         Refresh,
    input  logic                         Lista,
    input  logic                         Row_Done,
    output logic [ROW_BITS-1:0]          Row_DB,
    output logic                         Row_Write,
    output logic                         LCD_RS,
    output logic                         Cmd_Write,
    output logic [7:0]                   Cmd_Data,
    output logic                         Busy,
    output logic                         Frame_Done
);

    localparam int RW = row_idx_w(N_ROWS);

    state_t            state, state_nxt;
    logic [N_ROWS-1:0] pending;
    logic [N_ROWS-1:0] clear_mask;
    logic [RW-1:0]     last_row;
    logic [RW-1:0]     pick_sel;
    logic              pick_valid;
    logic [4:0]        char_cnt;
    logic              frame_done_set;

    lcd_rr_pick #(
        .N_ROWS (N_ROWS)
    ) u_pick (
        .pending  (pending),
        .last_row (last_row),
        .sel      (pick_sel),
        .valid    (pick_valid)
    );

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        // NOTE: state is updated with <= so every register samples the values
        // from before the edge, independent of block ordering.
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending bits: new requests win over the clear of the row being picked.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clear_mask) | Row_Req | {N_ROWS{Refresh}};
        end
    end

    // Row selection bookkeeping and image capture, both only in PICK.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            last_row <= RW'(N_ROWS - 1);
            Row_DB   <= '0;
        end else if (state == ST_PICK && pick_valid) begin
            last_row <= pick_sel;
            Row_DB   <= DB_All[int'(pick_sel)*ROW_BITS +: ROW_BITS];
        end
    end

    // Character ack counter, cleared on row start and saturating at CHARS.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            char_cnt <= '0;
        end else if (state == ST_ROW_START) begin
            char_cnt <= '0;
        end else if (state == ST_ROW_DATA && Lista && char_cnt < 5'(CHARS)) begin
            char_cnt <= char_cnt + 5'd1;
        end
    end

    // Registered end-of-frame pulse, high for the first IDLE cycle.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= frame_done_set;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt      = state;
        clear_mask     = '0;
        frame_done_set = 1'b0;
        Row_Write      = 1'b0;
        LCD_RS         = 1'b0;
        Cmd_Write      = 1'b0;
        Cmd_Data       = 8'h00;
        Busy           = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_nxt = ST_PICK;
                end
            end

            ST_PICK: begin
                if (pick_valid) begin
                    clear_mask           = '0;
                    clear_mask[pick_sel] = 1'b1;
                    state_nxt            = ST_CMD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_CMD: begin
                // last_row already holds the row picked for this transfer.
                Cmd_Write = 1'b1;
                Cmd_Data  = CMD_SET_DDRAM | ddram_base(int'(last_row));
                if (Lista) begin
                    state_nxt = ST_ROW_START;
                end
            end

            ST_ROW_START: begin
                Row_Write = 1'b1;
                LCD_RS    = 1'b1;
                state_nxt = ST_ROW_DATA;
            end

            ST_ROW_DATA: begin
                LCD_RS = 1'b1;
                if (Lista && char_cnt >= 5'(CHARS - 1)) begin
                    state_nxt = ST_ROW_END;
                end
            end

            ST_ROW_END: begin
                if (Row_Done) begin
                    if (pending != '0) begin
                        state_nxt = ST_PICK;
                    end else begin
                        frame_done_set = 1'b1;
                        state_nxt      = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_row_scheduler.sv
// Self-checking bench for lcd_row_scheduler (4-row configuration) against a
// transaction-level model: a pending-row set served round-robin.
module tb_lcd_row_scheduler;

    localparam int N  = 4;
    localparam int CH = 20;
    localparam int W  = 160;

    logic           CLK      = 1'b0;
    logic           Reset    = 1'b0;
    logic [N*W-1:0] DB_All   = '0;
    logic [N-1:0]   Row_Req  = '0;
    logic           Refresh  = 1'b0;
    logic           Lista    = 1'b0;
    logic           Row_Done = 1'b0;
    logic [W-1:0]   Row_DB;
    logic           Row_Write;
    logic           LCD_RS;
    logic           Cmd_Write;
    logic [7:0]     Cmd_Data;
    logic           Busy;
    logic           Frame_Done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [N-1:0] mdl_pend = '0;
    int           mdl_last = N - 1;
    logic [7:0]   exp_base [N] = '{8'h00, 8'h40, 8'h14, 8'h54};
    int           served [$];

    always #5 CLK = ~CLK;

    lcd_row_scheduler #(
        .N_ROWS (N),
        .CHARS  (CH)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .DB_All     (DB_All),
        .Row_Req    (Row_Req),
        .Refresh    (Refresh),
        .Lista      (Lista),
        .Row_Done   (Row_Done),
        .Row_DB     (Row_DB),
        .Row_Write  (Row_Write),
        .LCD_RS     (LCD_RS),
        .Cmd_Write  (Cmd_Write),
        .Cmd_Data   (Cmd_Data),
        .Busy       (Busy),
        .Frame_Done (Frame_Done)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic randomize_db();
        for (int i = 0; i < N*W/32; i++) DB_All[i*32 +: 32] = $urandom();
    endtask

    // Next row to serve: first pending row after the last one served.
    function automatic int mdl_pick();
        for (int k = 1; k <= N; k++) begin
            int r;
            r = (mdl_last + k) % N;
            if (mdl_pend[r]) return r;
        end
        return -1;
    endfunction

    // Serve one row transfer as the byte driver and row register would.
    task automatic serve_row(input int glo, input int ghi, input logic [N-1:0] inj_req,
                             input logic inj_ref, input bit new_db,
                             output bit done, output int row);
        int           waited;
        int           exp_row;
        logic [W-1:0] exp_img;
        logic [7:0]   exp_cmd;
        done   = 0;
        row    = -1;
        waited = 0;
        while (Cmd_Write !== 1'b1 && waited < 16) begin
            step();
            waited++;
        end
        n_checks++;
        if (Cmd_Write !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_timeout: Cmd_Write=%b after %0d cycles, required 1", Cmd_Write, waited);
            return;
        end
        exp_row = mdl_pick();
        n_checks++;
        if (exp_row < 0) begin
            n_fail++;
            $display("FAIL spurious_row: Cmd_Data=%h issued with no pending row", Cmd_Data);
            return;
        end
        row                = exp_row;
        mdl_pend[exp_row]  = 1'b0;
        mdl_last           = exp_row;
        exp_img            = DB_All[exp_row*W +: W];
        exp_cmd            = 8'h80 | exp_base[exp_row];

        n_checks++;
        if ({Cmd_Data, LCD_RS, Busy} !== {exp_cmd, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL cmd_data: Cmd_Data=%h RS=%b Busy=%b, required %h 0 1", Cmd_Data, LCD_RS, Busy, exp_cmd);
        end
        n_checks++;
        if (Row_DB !== exp_img) begin
            n_fail++;
            $display("FAIL row_db_latch: row %0d Row_DB=%h, required %h", exp_row, Row_DB, exp_img);
        end

        // Command phase held a few cycles; a stray Row_Done must be ignored.
        repeat ($urandom_range(0, 3)) begin
            Row_Done = 1'($urandom_range(0, 1));
            step();
            Row_Done = 1'b0;
            n_checks++;
            if ({Cmd_Write, Cmd_Data} !== {1'b1, exp_cmd}) begin
                n_fail++;
                $display("FAIL cmd_hold: Cmd_Write=%b Cmd_Data=%h, required 1 %h", Cmd_Write, Cmd_Data, exp_cmd);
            end
        end
        Lista = 1'b1;
        step();
        Lista = 1'b0;
        n_checks++;
        if ({Row_Write, LCD_RS, Cmd_Write} !== 3'b110) begin
            n_fail++;
            $display("FAIL row_start: Row_Write/RS/Cmd_Write=%b, required 110", {Row_Write, LCD_RS, Cmd_Write});
        end
        // A Lista in the start cycle must not count as a character.
        Lista = 1'($urandom_range(0, 1));
        step();
        Lista = 1'b0;
        n_checks++;
        if ({Row_Write, LCD_RS} !== 2'b01) begin
            n_fail++;
            $display("FAIL row_write_pulse: Row_Write/RS=%b, required 01", {Row_Write, LCD_RS});
        end

        for (int c = 0; c < CH; c++) begin
            repeat ($urandom_range(glo, ghi)) step();
            if (c == 10 && (inj_req != '0 || inj_ref || new_db)) begin
                Row_Req = inj_req;
                Refresh = inj_ref;
                if (new_db) randomize_db();
                step();
                Row_Req  = '0;
                Refresh  = 1'b0;
                mdl_pend = mdl_pend | inj_req | {N{inj_ref}};
            end
            n_checks++;
            if (LCD_RS !== 1'b1) begin
                n_fail++;
                $display("FAIL rs_data: before ack %0d LCD_RS=%b, required 1", c, LCD_RS);
            end
            Lista = 1'b1;
            step();
            Lista = 1'b0;
        end

        n_checks++;
        if ({LCD_RS, Busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rs_end: after %0d acks RS/Busy=%b, required 01", CH, {LCD_RS, Busy});
        end
        repeat ($urandom_range(0, 3)) step();
        n_checks++;
        if (Row_DB !== exp_img) begin
            n_fail++;
            $display("FAIL row_db_hold: row %0d Row_DB=%h, required %h", exp_row, Row_DB, exp_img);
        end
        Row_Done = 1'b1;
        step();
        Row_Done = 1'b0;
        if (mdl_pend != '0) begin
            n_checks++;
            if ({Busy, Frame_Done} !== 2'b10) begin
                n_fail++;
                $display("FAIL next_row: Busy/Frame_Done=%b, required 10", {Busy, Frame_Done});
            end
        end else begin
            n_checks++;
            if ({Busy, Frame_Done} !== 2'b01) begin
                n_fail++;
                $display("FAIL frame_done: Busy/Frame_Done=%b, required 01", {Busy, Frame_Done});
            end
            step();
            n_checks++;
            if ({Busy, Frame_Done} !== 2'b00) begin
                n_fail++;
                $display("FAIL frame_done_pulse: Busy/Frame_Done=%b, required 00", {Busy, Frame_Done});
            end
            done = 1;
        end
    endtask

    // Raise requests from IDLE and serve rows until the frame completes.
    task automatic run_frame(input logic [N-1:0] mask, input logic ref_all, input int glo, input int ghi,
                             input logic [N-1:0] inj_req, input logic inj_ref, input bit new_db);
        bit done;
        int row;
        done = 0;
        served.delete();
        Row_Req = mask;
        Refresh = ref_all;
        step();
        Row_Req  = '0;
        Refresh  = 1'b0;
        mdl_pend = mdl_pend | mask | {N{ref_all}};
        for (int i = 0; i < 12 && !done; i++) begin
            if (i == 0) serve_row(glo, ghi, inj_req, inj_ref, new_db, done, row);
            else        serve_row(glo, ghi, '0, 1'b0, new_db, done, row);
            if (row < 0) break;
            served.push_back(row);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL frame_timeout: frame not completed after %0d rows", served.size());
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({Busy, Row_Write, LCD_RS, Cmd_Write, Frame_Done, Cmd_Data, Row_DB} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: Busy=%b RW=%b RS=%b CW=%b FD=%b Cmd=%h, required all 0",
                     Busy, Row_Write, LCD_RS, Cmd_Write, Frame_Done, Cmd_Data);
        end
        Reset = 1'b1;
        step();
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: Busy=%b, required 0", Busy);
        end
    endtask

    task automatic test_idle_ignores();
        Lista = 1'b1;
        step();
        Lista    = 1'b0;
        Row_Done = 1'b1;
        step();
        Row_Done = 1'b0;
        step();
        n_checks++;
        if ({Busy, Frame_Done, Cmd_Write, LCD_RS} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ignores: Busy/FD/CW/RS=%b, required 0000", {Busy, Frame_Done, Cmd_Write, LCD_RS});
        end
    endtask

    task automatic test_single_row();
        randomize_db();
        run_frame(4'b0001, 1'b0, 3, 3, '0, 1'b0, 1'b0);
        n_checks++;
        if (served.size() != 1 || served[0] != 0) begin
            n_fail++;
            $display("FAIL single_row: served %0d rows first=%0d, required 1 row 0", served.size(), served.size() ? served[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        randomize_db();
        run_frame(4'b0011, 1'b0, 0, 2, '0, 1'b0, 1'b0);
        n_checks++;
        if (served.size() != 2 || served[0] != 1 || served[1] != 0) begin
            n_fail++;
            $display("FAIL round_robin: served %p, required '{1,0}", served);
        end
    endtask

    task automatic test_requeue();
        randomize_db();
        run_frame(4'b0010, 1'b0, 0, 2, 4'b0010, 1'b0, 1'b1);
        n_checks++;
        if (served.size() != 2 || served[0] != 1 || served[1] != 1) begin
            n_fail++;
            $display("FAIL requeue: served %p, required '{1,1}", served);
        end
    endtask

    task automatic test_reset_mid_row();
        int waited;
        waited  = 0;
        Row_Req = 4'b0100;
        step();
        Row_Req = '0;
        while (Cmd_Write !== 1'b1 && waited < 16) begin
            step();
            waited++;
        end
        Lista = 1'b1;
        step();
        Lista = 1'b0;
        step();
        repeat (5) begin
            Lista = 1'b1;
            step();
            Lista = 1'b0;
            step();
        end
        n_checks++;
        if ({Busy, LCD_RS} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_row_setup: Busy/RS=%b, required 11", {Busy, LCD_RS});
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Row_Write, LCD_RS, Cmd_Write, Frame_Done, Cmd_Data, Row_DB} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: Busy=%b RW=%b RS=%b CW=%b FD=%b Cmd=%h, required all 0",
                     Busy, Row_Write, LCD_RS, Cmd_Write, Frame_Done, Cmd_Data);
        end
        #3;
        Reset    = 1'b1;
        mdl_pend = '0;
        mdl_last = N - 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({Busy, Frame_Done, Cmd_Write, Row_Write} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_release: cycle %0d Busy/FD/CW/RW=%b, required 0000", i, {Busy, Frame_Done, Cmd_Write, Row_Write});
            end
        end
    endtask

    task automatic test_refresh();
        randomize_db();
        run_frame('0, 1'b1, 0, 3, '0, 1'b0, 1'b0);
        n_checks++;
        if (served.size() != 4 || served[0] != 0 || served[1] != 1 || served[2] != 2 || served[3] != 3) begin
            n_fail++;
            $display("FAIL refresh_order: served %p, required '{0,1,2,3}", served);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            logic [N-1:0] mask;
            logic [N-1:0] inj;
            logic         inj_ref;
            mask    = N'($urandom_range(1, (1 << N) - 1));
            inj     = ($urandom_range(0, 1) != 0) ? N'($urandom()) : '0;
            inj_ref = ($urandom_range(0, 3) == 0);
            randomize_db();
            run_frame(mask, 1'b0, 0, 3, inj, inj_ref, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignores();
        test_single_row();
        test_round_robin();
        test_requeue();
        test_reset_mid_row();
        test_refresh();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
